// File: rtl/multicycle_control_if.sv
// Bundles the instruction, status and control signals between the multicycle
// controller and its datapath.
//   master : controller side (drives ALUop, strobes, pc_src, state, counters)
//   slave  : datapath side (drives opcode, function_code, zero, mem_ready)
interface multicycle_control_if;
  logic [5:0]  opcode;
  logic [5:0]  function_code;
  logic        zero;
  logic        mem_ready;
  logic [2:0]  ALUop;
  logic        mem_req;
  logic        mem_write;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic        reg_dst;
  logic        alu_src;
  logic        mem_to_reg;
  logic [1:0]  pc_src;
  logic [2:0]  state;
  logic [15:0] instr_retired;
  logic        trap;

  modport master (
    input  opcode, function_code, zero, mem_ready,
    output ALUop, mem_req, mem_write, ir_write, pc_write, reg_write, reg_dst,
           alu_src, mem_to_reg, pc_src, state, instr_retired, trap
  );

  modport slave (
    output opcode, function_code, zero, mem_ready,
    input  ALUop, mem_req, mem_write, ir_write, pc_write, reg_write, reg_dst,
           alu_src, mem_to_reg, pc_src, state, instr_retired, trap
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP FSM
// with a 16-bit retired-instruction counter.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : multicycle_control_if.master (instruction fields, ALU zero,
//             memory ready in; ALUop, datapath strobes, pc_src, state,
//             instr_retired, trap out)
// Build option: define ILLEGAL_TRAP_EN to send illegal encodings to a sticky
// TRAP state; otherwise they retire as NOPs and trap is tied low.
module multicycle_control (
  input logic                  clk,
  input logic                  reset_n,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd6
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] FnJr    = 6'b001000;

  function automatic logic legal_instr(input logic [5:0] op, input logic [5:0] fn);
    legal_instr = 1'b0;
    case (op)
      OpRtype: begin
        case (fn)
          6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, FnJr: legal_instr = 1'b1;
          default: legal_instr = 1'b0;
        endcase
      end
      OpJ, OpBeq, OpAddi, OpSlti, OpAndi, OpOri, OpLw, OpSw: legal_instr = 1'b1;
      default: legal_instr = 1'b0;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [5:0]  opcode_q, funct_q;
  logic [15:0] retired_q;
  logic        retire;
  logic        is_j, is_jr, is_legal;

  // DECODE dispatches on the live IR fields; later states use the latched copy.
  always_comb begin
    is_j     = (bus.opcode == OpJ);
    is_jr    = (bus.opcode == OpRtype) && (bus.function_code == FnJr);
    is_legal = legal_instr(bus.opcode, bus.function_code);
  end

  always_comb begin
    state_d        = state_q;
    retire         = 1'b0;
    bus.ALUop      = 3'b101;
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.alu_src    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.pc_src     = 2'b00;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = StDecode;
        end
      end
      StDecode: begin
        if (is_j) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = 2'b10;
          retire       = 1'b1;
          state_d      = StFetch;
        end else if (is_jr) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = 2'b11;
          retire       = 1'b1;
          state_d      = StFetch;
        end else if (!is_legal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = StTrap;
`else
          retire  = 1'b1;
          state_d = StFetch;
`endif
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        // The latched pair is legal by construction; guard anyway so an
        // unexpected encoding can never wedge the FSM.
        if (!legal_instr(opcode_q, funct_q)) begin
          state_d = StFetch;
        end else begin
          case (opcode_q)
            OpRtype: begin bus.ALUop = 3'b111; state_d = StWb; end
            OpLw, OpSw: begin bus.ALUop = 3'b101; bus.alu_src = 1'b1; state_d = StMem; end
            OpAddi: begin bus.ALUop = 3'b101; bus.alu_src = 1'b1; state_d = StWb; end
            OpAndi: begin bus.ALUop = 3'b000; bus.alu_src = 1'b1; state_d = StWb; end
            OpOri:  begin bus.ALUop = 3'b001; bus.alu_src = 1'b1; state_d = StWb; end
            OpSlti: begin bus.ALUop = 3'b100; bus.alu_src = 1'b1; state_d = StWb; end
            OpBeq: begin
              bus.ALUop    = 3'b110;
              bus.pc_write = bus.zero;
              bus.pc_src   = {1'b0, bus.zero};
              retire       = 1'b1;
              state_d      = StFetch;
            end
            default: state_d = StFetch;
          endcase
        end
      end
      StMem: begin
        bus.mem_req   = 1'b1;
        bus.mem_write = (opcode_q == OpSw);
        if (bus.mem_ready) begin
          if (opcode_q == OpSw) begin
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = (opcode_q == OpRtype);
        bus.mem_to_reg = (opcode_q == OpLw);
        retire         = 1'b1;
        state_d        = StFetch;
      end
      StTrap: state_d = StTrap;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      opcode_q  <= '0;
      funct_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        opcode_q <= bus.opcode;
        funct_q  <= bus.function_code;
      end
      if (retire) retired_q <= retired_q + 16'd1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trap_q <= 1'b0;
    end else if (state_d == StTrap) begin
      trap_q <= 1'b1;
    end
  end
  assign bus.trap = trap_q;
`else
  assign bus.trap = 1'b0;
`endif

  assign bus.state         = state_q;
  assign bus.instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control. A per-instruction
// model expands each instruction class into its expected cycle sequence and
// checks state, ALUop, strobes, pc_src, instr_retired and trap every cycle.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset_n;

  multicycle_control_if bus();

  multicycle_control dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Strobe bits: {mem_req, mem_write, ir_write, pc_write, reg_write, reg_dst, alu_src, mem_to_reg}
  localparam logic [7:0] SMreq = 8'h80, SMwr = 8'h40, SIrw = 8'h20, SPcw = 8'h10;
  localparam logic [7:0] SRegw = 8'h08, SDst = 8'h04, SAlus = 8'h02, SM2r = 8'h01;

  typedef enum {IkR, IkImm, IkLw, IkSw, IkBeq, IkJ, IkJr, IkIll} kind_e;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [15:0] exp_retired;
  logic        exp_trap;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        case (fn)
          6'b001000: return IkJr;
          6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return IkR;
          default: return IkIll;
        endcase
      end
      6'b000010: return IkJ;
      6'b000100: return IkBeq;
      6'b001000, 6'b001010, 6'b001100, 6'b001101: return IkImm;
      6'b100011: return IkLw;
      6'b101011: return IkSw;
      default: return IkIll;
    endcase
  endfunction

  function automatic logic [2:0] exec_aluop(input logic [5:0] op);
    case (op)
      6'b000000: return 3'b111;
      6'b001100: return 3'b000;
      6'b001101: return 3'b001;
      6'b001010: return 3'b100;
      6'b000100: return 3'b110;
      default:   return 3'b101;
    endcase
  endfunction

  task automatic expect_cycle(input string tag, input logic [2:0] st, input logic [2:0] aluop,
                              input logic [7:0] strobes, input logic [1:0] pcs, input bit chk_pc);
    logic [7:0] got_s;
    got_s = {bus.mem_req, bus.mem_write, bus.ir_write, bus.pc_write,
             bus.reg_write, bus.reg_dst, bus.alu_src, bus.mem_to_reg};
    check_eq({tag, "/state"}, 32'(bus.state), 32'(st));
    check_eq({tag, "/aluop"}, 32'(bus.ALUop), 32'(aluop));
    check_eq({tag, "/strobes"}, 32'(got_s), 32'(strobes));
    if (chk_pc) check_eq({tag, "/pc_src"}, 32'(bus.pc_src), 32'(pcs));
    check_eq({tag, "/retired"}, 32'(bus.instr_retired), 32'(exp_retired));
    check_eq({tag, "/trap"}, 32'(bus.trap), 32'(exp_trap));
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    exp_retired = '0;
    exp_trap    = 1'b0;
    #1;
    expect_cycle("rst_async", 3'd0, 3'b101, 8'h00, 2'b00, 1);
    @(negedge clk);
    #1;
    expect_cycle("rst_hold", 3'd0, 3'b101, 8'h00, 2'b00, 1);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    expect_cycle("idle", 3'd0, 3'b101, 8'h00, 2'b00, 1);
  endtask

  task automatic randomize_misc();
    bus.zero      = 1'($urandom);
    bus.mem_ready = 1'($urandom);
  endtask

  // Runs one instruction from its first FETCH cycle to the cycle it completes.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero_v,
                           input int fstall, input int mstall, input bit abort_mem);
    kind_e k;
    k = classify(op, fn);
    for (int i = 0; i <= fstall; i++) begin
      @(negedge clk);
      bus.opcode = op; bus.function_code = fn; bus.zero = 1'($urandom);
      bus.mem_ready = (i == fstall);
      #1;
      expect_cycle("fetch", 3'd1, 3'b101, (i == fstall) ? (SMreq | SIrw | SPcw) : SMreq, 2'b00, 1);
    end
    @(negedge clk);
    randomize_misc();
    #1;
    if (k == IkJ || k == IkJr) begin
      expect_cycle("decode_jump", 3'd2, 3'b101, SPcw, (k == IkJ) ? 2'b10 : 2'b11, 1);
      exp_retired++;
      return;
    end
    expect_cycle("decode", 3'd2, 3'b101, 8'h00, 2'b00, 1);
    if (k == IkIll) begin
`ifdef ILLEGAL_TRAP_EN
      exp_trap = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        bus.opcode = 6'($urandom); bus.function_code = 6'($urandom); randomize_misc();
        #1;
        expect_cycle("trap", 3'd6, 3'b101, 8'h00, 2'b00, 1);
      end
      do_reset();
`else
      exp_retired++;
`endif
      return;
    end
    // Later states must use the instruction captured in DECODE.
    @(negedge clk);
    bus.opcode = 6'($urandom); bus.function_code = 6'($urandom);
    bus.zero = zero_v; bus.mem_ready = 1'($urandom);
    #1;
    if (k == IkBeq) begin
      expect_cycle("exec_beq", 3'd3, 3'b110, zero_v ? SPcw : 8'h00, 2'b01, zero_v);
      exp_retired++;
      return;
    end
    expect_cycle("exec", 3'd3, exec_aluop(op), (k == IkR) ? 8'h00 : SAlus, 2'b00, 1);
    if (k == IkLw || k == IkSw) begin
      for (int i = 0; i <= mstall; i++) begin
        @(negedge clk);
        bus.zero = 1'($urandom); bus.mem_ready = (i == mstall);
        #1;
        expect_cycle("mem", 3'd4, 3'b101, (k == IkSw) ? (SMreq | SMwr) : SMreq, 2'b00, 1);
        if (abort_mem) begin
          do_reset();
          return;
        end
      end
      if (k == IkSw) begin
        exp_retired++;
        return;
      end
    end
    @(negedge clk);
    randomize_misc();
    #1;
    case (k)
      IkLw:    expect_cycle("wb_lw", 3'd5, 3'b101, SRegw | SM2r, 2'b00, 1);
      IkR:     expect_cycle("wb_r", 3'd5, 3'b101, SRegw | SDst, 2'b00, 1);
      default: expect_cycle("wb_imm", 3'd5, 3'b101, SRegw, 2'b00, 1);
    endcase
    exp_retired++;
  endtask

  logic [5:0] op_pool [10] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h23, 6'h2b, 6'h3f};
  logic [5:0] fn_pool [7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h08, 6'h11};

  initial begin
    reset_n = 1'b1;
    bus.opcode = '0; bus.function_code = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    exp_retired = '0; exp_trap = 1'b0;
    #2;
    do_reset();

    run_instr(6'h00, 6'h20, 1'b0, 0, 0, 0);   // add
    run_instr(6'h23, 6'h00, 1'b0, 0, 3, 0);   // lw, 3 stall cycles in MEM
    run_instr(6'h04, 6'h00, 1'b1, 0, 0, 0);   // beq taken
    run_instr(6'h04, 6'h00, 1'b0, 0, 0, 0);   // beq not taken
    run_instr(6'h2b, 6'h00, 1'b0, 2, 1, 0);   // sw with stalls
    run_instr(6'h3f, 6'h00, 1'b0, 0, 0, 0);   // illegal opcode
    run_instr(6'h00, 6'h08, 1'b0, 0, 0, 0);   // jr
    run_instr(6'h2b, 6'h00, 1'b0, 0, 2, 1);   // sw, reset during MEM

    // Counter wrap: preload 0xFFFF during a fetch stall, then retire one j.
    @(negedge clk);
    bus.mem_ready = 1'b0;
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    exp_retired = 16'hFFFF;
    expect_cycle("preload", 3'd1, 3'b101, SMreq, 2'b00, 1);
    run_instr(6'h02, 6'h00, 1'b0, 0, 0, 0);
    check_eq("wrap", 32'(exp_retired), 32'h0);

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op, fn;
      op = op_pool[$urandom_range(9)];
      fn = (op == 6'h00) ? fn_pool[$urandom_range(6)] : 6'($urandom);
      run_instr(op, fn, 1'($urandom), $urandom_range(2), $urandom_range(3), 0);
    end
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    expect_cycle("final", 3'd1, 3'b101, SMreq, 2'b00, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 opcode  input  6  instruction bits [31:26] from the external IR.
REQ-004 function_code  input  6  instruction bits [5:0] from the external IR.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completes the current request this cycle.
REQ-007 ALUop  output  3  to alu_control: 111 R-type, 101 add, 110 sub, 000 and, 001 or, 100 slt.
REQ-008 mem_req, mem_write, ir_write, pc_write, reg_write, reg_dst, alu_src, mem_to_reg  output  1 each  datapath strobes and selects.
REQ-009 pc_src  output  2  00 ALU (PC+4), 01 branch target, 10 jump target, 11 register (jr).
REQ-010 state  output  3  current FSM state encoding.
REQ-011 instr_retired  output  16  retired-instruction counter.
REQ-012 trap  output  1  sticky illegal-instruction flag (see Configuration).

Function
REQ-013 States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; state is registered and all outputs decode combinationally from state plus the latched opcode/function.
REQ-014 IDLE -> FETCH unconditionally; all strobes 0 in IDLE.
REQ-015 FETCH: mem_req=1, ALUop=101; hold while mem_ready=0; when mem_ready=1, pulse ir_write=1 and pc_write=1 (pc_src=00) and go to DECODE.
REQ-016 DECODE: latch opcode and function_code; ALUop=101 (branch-target add); j (000010) -> pc_write=1, pc_src=10, retire, FETCH; jr (R-type, funct 001000) -> pc_write=1, pc_src=11, retire, FETCH; other legal opcodes -> EXEC.
REQ-017 EXEC ALUop: R-type 111; lw/sw/addi 101; andi 000; ori 001; slti 100; beq 110; alu_src=1 for all except R-type and beq.
REQ-018 EXEC next: lw/sw -> MEM; beq -> pc_write=zero, pc_src=01, retire, FETCH; R-type/immediate -> WB.
REQ-019 MEM: mem_req=1, mem_write=1 for sw only; hold while mem_ready=0; on mem_ready lw -> WB, sw retires -> FETCH.
REQ-020 WB: reg_write=1 for one cycle; reg_dst=1 for R-type only; mem_to_reg=1 for lw only; retire; -> FETCH.
REQ-021 Latencies with mem_ready tied to 1: j/jr 2, beq 3, R-type/imm/sw 4, lw 5 cycles.
REQ-022 ALUop=101 in all states other than EXEC; strobes not listed for a state are 0.
REQ-023 Retire = instr_retired increments by 1 on the cycle that leaves the completing state; wraps 0xFFFF -> 0x0000.
REQ-024 mem_req stays asserted continuously across mem_ready=0 stall cycles; no strobe repeats during a stall.

Reset
REQ-025 reset_n=0 forces state=IDLE, instr_retired=0, trap=0 and latched opcode/function=0 immediately, including mid-instruction.
REQ-026 While reset_n=0 all outputs are 0 except ALUop=101 and state=000; first FETCH occurs one cycle after release.

Configuration
REQ-027 Macro ILLEGAL_TRAP_EN.
REQ-028 Defined: an unlisted opcode, or an R-type funct outside {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 001000 jr}, sends DECODE -> TRAP; trap=1 and all strobes 0 until reset; no retire.
REQ-029 Undefined: the same encodings retire as NOP from DECODE -> FETCH; trap is tied to 0 and TRAP state is unreachable.

Verification
REQ-030 add R-type (000000/100000), mem_ready=1 -> states 1,2,3,5,1; ALUop=111 in EXEC; reg_write and reg_dst =1 in WB; instr_retired +1.
REQ-031 lw (100011) with mem_ready low for 3 cycles in MEM -> MEM held 4 cycles, mem_req high throughout, mem_write=0, WB mem_to_reg=1; 5+3 cycles total.
REQ-032 beq (000100) zero=1 then zero=0 -> EXEC ALUop=110; pc_write=1 pc_src=01 only in the first case; both take 3 cycles.
REQ-033 opcode 111111 -> with ILLEGAL_TRAP_EN state=6, trap=1, strobes 0 for 10 cycles; without, FETCH follows DECODE and instr_retired +1.
REQ-034 reset_n pulsed low during MEM of sw -> mem_req/mem_write drop immediately, instr_retired=0, state 0 then 1 after release.
REQ-035 preload 0xFFFF retirements then one j -> instr_retired=0x0000; pc_src=10 in DECODE.
